// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared press-FSM state type and 100 MHz timing constants for the button front end
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } press_state_e;

  localparam int unsigned DB_10MS = 1_000_000;
  localparam int unsigned LONG_1S = 100_000_000;

endpackage

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one button channel: 2-FF sync, debounce, edge pulses, long-press FSM
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_10MS,
  parameter int unsigned LONG_CYCLES = LONG_1S
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic en_i,
  output logic key_db_o,
  output logic rise_p_o,
  output logic fall_p_o,
  output logic long_p_o
);

  localparam int unsigned DW = $clog2(DB_CYCLES);
  localparam int unsigned LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          key_q;
  logic          key_prev_q;
  logic [DW-1:0] dcnt_q;
  logic [LW-1:0] lcnt_q;
  logic          rise_q;
  logic          fall_q;
  logic          long_q;
  press_state_e  st_q;

  logic s;
  logic rise_d;
  logic fall_d;

  assign s      = sync_q[1];
  assign rise_d = key_q & ~key_prev_q;
  assign fall_d = ~key_q & key_prev_q;

  // The FSM reacts to the same edge condition that registers rise_p/fall_p,
  // so its state is already PRESS while rise_p is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      key_q      <= 1'b0;
      key_prev_q <= 1'b0;
      dcnt_q     <= '0;
      lcnt_q     <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      long_q     <= 1'b0;
      st_q       <= IDLE;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      key_prev_q <= key_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      long_q     <= 1'b0;

      if (s == key_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DB_MAX) begin
        key_q  <= s;
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end

      case (st_q)
        IDLE: begin
          if (rise_d) begin
            st_q   <= PRESS;
            lcnt_q <= '0;
          end
        end
        PRESS: begin
          if (fall_d) begin
            st_q <= IDLE;
          end else if (lcnt_q == LONG_MAX) begin
            st_q   <= LONG;
            long_q <= en_i;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        LONG: begin
          if (fall_d) st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign key_db_o = key_q;
  assign rise_p_o = rise_q;
  assign fall_p_o = fall_q;
  assign long_p_o = long_q;

endmodule

// File: rtl/btn_mode_ctrl.sv
// rtl/btn_mode_ctrl.sv - N-channel button front end with toggle/hold state and run-flag gating
module btn_mode_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned           N_BTN       = 4,
  parameter int unsigned           DB_CYCLES   = DB_10MS,
  parameter int unsigned           LONG_CYCLES = LONG_1S,
  parameter logic [N_BTN-1:0]      TOGGLE_MASK = N_BTN'(4'b0011),
  parameter logic [N_BTN-1:0]      GATE_MASK   = N_BTN'(4'b0100),
  parameter int unsigned           RUN_IDX     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] key_db,
  output logic [N_BTN-1:0] rise_p,
  output logic [N_BTN-1:0] fall_p,
  output logic [N_BTN-1:0] long_p,
  output logic [N_BTN-1:0] state_q
);

  logic [N_BTN-1:0] en;
  logic [N_BTN-1:0] state_d;

  // Gate uses the registered (pre-update) run flag, so a run toggle in the
  // same cycle cannot change this cycle's decision.
  assign en = ~GATE_MASK | {N_BTN{~state_q[RUN_IDX]}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn[i]),
      .en_i    (en[i]),
      .key_db_o(key_db[i]),
      .rise_p_o(rise_p[i]),
      .fall_p_o(fall_p[i]),
      .long_p_o(long_p[i])
    );
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (TOGGLE_MASK[i]) begin
        if (rise_p[i] && en[i]) state_d[i] = ~state_q[i];
      end else begin
        if (fall_p[i])                state_d[i] = 1'b0;
        else if (rise_p[i] && en[i])  state_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= '0;
    else      state_q <= state_d;
  end

endmodule
